grf_scoreboard: RTL and testbench

- Tracks in-flight writes to the general register file.
- Tells the decode stage when a source register cannot yet be read or forwarded.
- Issue side: decode announces each destination register and its remaining result latency (Tnew).
- Retire side: observes the GRF write port and clears the matching pending entry.
- Single stall output feeds the pipeline freeze logic; per-source pending flags feed forwarding select.

---
 rtl/grf_scoreboard_if.sv | 35 +++
 rtl/grf_scoreboard.sv | 97 +++++++++
 tb/tb_grf_scoreboard.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/grf_scoreboard_if.sv
// Decode/writeback-facing bundle of the GRF scoreboard.
// The master side (decode/writeback) drives requests; the slave side (the scoreboard) drives the status.
interface grf_scoreboard_if #(
    parameter int TW = 3
);
    logic          issue_valid;
    logic [4:0]    issue_waddr;
    logic [TW-1:0] issue_tnew;
    logic [31:0]   issue_pc;
    logic [4:0]    rs_addr;
    logic [TW-1:0] rs_tuse;
    logic [4:0]    rt_addr;
    logic [TW-1:0] rt_tuse;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic          flush;
    logic          stall;
    logic          rs_pending;
    logic          rt_pending;
    logic [5:0]    busy_count;

    modport master (
        output issue_valid, issue_waddr, issue_tnew, issue_pc,
        output rs_addr, rs_tuse, rt_addr, rt_tuse,
        output wb_en, wb_addr, flush,
        input  stall, rs_pending, rt_pending, busy_count
    );

    modport slave (
        input  issue_valid, issue_waddr, issue_tnew, issue_pc,
        input  rs_addr, rs_tuse, rt_addr, rt_tuse,
        input  wb_en, wb_addr, flush,
        output stall, rs_pending, rt_pending, busy_count
    );
endinterface

// File: rtl/grf_scoreboard.sv
// In-flight GRF write tracker: per-register pending bit plus Tnew countdown, producing decode stall.
// Optional trace printing is enabled by defining SCOREBOARD_TRACE_EN.
module grf_scoreboard #(
    parameter int TW   = 3,
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              reset,
    grf_scoreboard_if.slave   sb
);
    logic [NREG-1:0] pending_q, pending_d;
    logic [TW-1:0]   cnt_q [NREG];
    logic [TW-1:0]   cnt_d [NREG];
    logic [5:0]      busy_q, busy_d;
    logic            rs_pend, rt_pend, stall_c, issue_acc;

    // Status is derived from registered state only; same-cycle issue/retire is not bypassed.
    always_comb begin
        rs_pend   = (sb.rs_addr != 5'd0) && pending_q[sb.rs_addr];
        rt_pend   = (sb.rt_addr != 5'd0) && pending_q[sb.rt_addr];
        stall_c   = (rs_pend && (cnt_q[sb.rs_addr] > sb.rs_tuse)) ||
                    (rt_pend && (cnt_q[sb.rt_addr] > sb.rt_tuse));
        issue_acc = sb.issue_valid && !stall_c && !sb.flush && (sb.issue_waddr != 5'd0);
    end

    assign sb.stall      = stall_c;
    assign sb.rs_pending = rs_pend;
    assign sb.rt_pending = rt_pend;
    assign sb.busy_count = busy_q;

    // Priority per entry, lowest to highest: countdown, retire, issue, flush.
    always_comb begin
        pending_d = '0;
        busy_d    = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = '0;
        end
        for (int r = 1; r < NREG; r++) begin
            pending_d[r] = pending_q[r];
            cnt_d[r]     = (pending_q[r] && (cnt_q[r] != '0)) ? cnt_q[r] - TW'(1) : cnt_q[r];
            if (sb.wb_en && (sb.wb_addr == 5'(r))) begin
                pending_d[r] = 1'b0;
                cnt_d[r]     = '0;
            end
            if (issue_acc && (sb.issue_waddr == 5'(r))) begin
                pending_d[r] = 1'b1;
                cnt_d[r]     = sb.issue_tnew;
            end
            if (sb.flush) begin
                pending_d[r] = 1'b0;
                cnt_d[r]     = '0;
            end
            busy_d = busy_d + 6'(pending_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            busy_q    <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            busy_q    <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef SCOREBOARD_TRACE_EN
    logic retire_clr;

    // A retire only counts as clearing when neither flush nor a same-register issue overrides it.
    always_comb begin
        retire_clr = sb.wb_en && (sb.wb_addr != 5'd0) && pending_q[sb.wb_addr] && !sb.flush &&
                     !(issue_acc && (sb.issue_waddr == sb.wb_addr));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (issue_acc) begin
                $display("%0t @%h: %0d pending tnew=%0d", $time, sb.issue_pc, sb.issue_waddr, sb.issue_tnew);
            end
            if (retire_clr) begin
                $display("%0t: %0d retired", $time, sb.wb_addr);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^sb.issue_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed checks of grf_scoreboard: reset, load-use stall, tuse cover, r0, collision, stall-ignore, flush, saturation.
module tb_grf_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    grf_scoreboard_if #(.TW(3)) sb_if ();

    grf_scoreboard #(.TW(3), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.issue_valid = 1'b0;
        sb_if.issue_waddr = 5'd0;
        sb_if.issue_tnew  = 3'd0;
        sb_if.wb_en       = 1'b0;
        sb_if.wb_addr     = 5'd0;
        sb_if.flush       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] wa, input logic [2:0] tn);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_waddr = wa;
        sb_if.issue_tnew  = tn;
        sb_if.issue_pc    = 32'h0000_3000 + {27'd0, wa};
    endtask

    task automatic src(input logic [4:0] rs, input logic [2:0] rsu,
                       input logic [4:0] rt, input logic [2:0] rtu);
        sb_if.rs_addr = rs;
        sb_if.rs_tuse = rsu;
        sb_if.rt_addr = rt;
        sb_if.rt_tuse = rtu;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        sb_if.issue_pc = 32'd0;
        src(5'd0, 3'd0, 5'd0, 3'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_stall", sb_if.stall, 0);
        chk("rst_rs_pend", sb_if.rs_pending, 0);
        chk("rst_rt_pend", sb_if.rt_pending, 0);
        chk("rst_busy", sb_if.busy_count, 0);

        // Load-use: r8 tnew=2 consumed at tuse=0
        issue(5'd8, 3'd2);
        step();
        idle();
        src(5'd8, 3'd0, 5'd0, 3'd0);
        #1;
        chk("lu_stall_c1", sb_if.stall, 1);
        chk("lu_rs_pend", sb_if.rs_pending, 1);
        chk("lu_busy", sb_if.busy_count, 1);
        step();
        chk("lu_stall_c2", sb_if.stall, 1);
        step();
        chk("lu_stall_c3", sb_if.stall, 0);
        chk("lu_rs_pend_c3", sb_if.rs_pending, 1);
        sb_if.wb_en   = 1'b1;
        sb_if.wb_addr = 5'd8;
        step();
        idle();
        #1;
        chk("lu_ret_pend", sb_if.rs_pending, 0);
        chk("lu_ret_busy", sb_if.busy_count, 0);

        // Tuse covers Tnew
        src(5'd0, 3'd0, 5'd0, 3'd0);
        issue(5'd9, 3'd2);
        step();
        idle();
        src(5'd0, 3'd0, 5'd9, 3'd2);
        #1;
        chk("tu_stall_c1", sb_if.stall, 0);
        chk("tu_rt_pend", sb_if.rt_pending, 1);
        step();
        chk("tu_stall_c2", sb_if.stall, 0);
        step();
        chk("tu_stall_c3", sb_if.stall, 0);
        chk("tu_rt_pend_c3", sb_if.rt_pending, 1);
        sb_if.wb_en   = 1'b1;
        sb_if.wb_addr = 5'd9;
        step();
        idle();
        #1;
        chk("tu_ret_busy", sb_if.busy_count, 0);

        // Register zero never pending
        src(5'd0, 3'd0, 5'd0, 3'd0);
        issue(5'd0, 3'd3);
        step();
        idle();
        #1;
        chk("r0_rs_pend", sb_if.rs_pending, 0);
        chk("r0_stall", sb_if.stall, 0);
        chk("r0_busy", sb_if.busy_count, 0);

        // Collision: issue wins over same-cycle retire
        issue(5'd5, 3'd1);
        step();
        issue(5'd5, 3'd3);
        sb_if.wb_en   = 1'b1;
        sb_if.wb_addr = 5'd5;
        step();
        idle();
        src(5'd5, 3'd0, 5'd0, 3'd0);
        #1;
        chk("col_rs_pend", sb_if.rs_pending, 1);
        chk("col_busy", sb_if.busy_count, 1);
        chk("col_stall_t0", sb_if.stall, 1);
        sb_if.rs_tuse = 3'd2;
        #1;
        chk("col_stall_t2", sb_if.stall, 1);
        sb_if.rs_tuse = 3'd3;
        #1;
        chk("col_stall_t3", sb_if.stall, 0);

        // Issue while stalled is ignored (r5 cnt=3 > tuse 0)
        sb_if.rs_tuse = 3'd0;
        issue(5'd12, 3'd1);
        #1;
        chk("stl_stall", sb_if.stall, 1);
        step();
        idle();
        src(5'd5, 3'd0, 5'd12, 3'd0);
        #1;
        chk("stl_rt_pend", sb_if.rt_pending, 0);
        chk("stl_busy", sb_if.busy_count, 1);
        sb_if.wb_en   = 1'b1;
        sb_if.wb_addr = 5'd5;
        step();
        idle();
        sb_if.wb_en   = 1'b1;
        sb_if.wb_addr = 5'd20;
        step();
        idle();
        #1;
        chk("ret_nonpend_busy", sb_if.busy_count, 0);

        // Flush priority over issue
        src(5'd0, 3'd0, 5'd0, 3'd0);
        issue(5'd3, 3'd4);
        step();
        issue(5'd4, 3'd4);
        step();
        issue(5'd7, 3'd4);
        step();
        idle();
        #1;
        chk("fl_busy_pre", sb_if.busy_count, 3);
        sb_if.flush = 1'b1;
        issue(5'd10, 3'd1);
        step();
        idle();
        src(5'd3, 3'd0, 5'd7, 3'd0);
        #1;
        chk("fl_busy", sb_if.busy_count, 0);
        chk("fl_rs3", sb_if.rs_pending, 0);
        chk("fl_rt7", sb_if.rt_pending, 0);
        src(5'd10, 3'd0, 5'd4, 3'd0);
        #1;
        chk("fl_rs10", sb_if.rs_pending, 0);
        chk("fl_rt4", sb_if.rt_pending, 0);

        // Countdown saturates at zero; entry stays pending
        src(5'd0, 3'd0, 5'd0, 3'd0);
        issue(5'd6, 3'd1);
        step();
        idle();
        src(5'd6, 3'd0, 5'd0, 3'd0);
        #1;
        chk("sat_stall_c1", sb_if.stall, 1);
        step();
        chk("sat_stall_c2", sb_if.stall, 0);
        step();
        chk("sat_stall_c3", sb_if.stall, 0);
        chk("sat_rs_pend", sb_if.rs_pending, 1);

        // Mid-operation reset discards entries
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mrst_busy", sb_if.busy_count, 0);
        chk("mrst_rs_pend", sb_if.rs_pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
